// File: rtl/adam_pause_seq.sv
// Ordered pause/resume sequencer: pauses enabled children in ascending order and resumes
// them in descending order. Supports per-stage ack timeouts with sticky error bits, and abort.
module adam_pause_seq #(
  parameter int NO_STAGES = 2,
  parameter int TO_WIDTH  = 16,
  parameter int IDX_WIDTH = (NO_STAGES > 1) ? $clog2(NO_STAGES) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pause_req,
  output logic                 o_pause_ack,
  input  logic [NO_STAGES-1:0] i_stage_en,
  output logic [NO_STAGES-1:0] o_stage_pause_req,
  input  logic [NO_STAGES-1:0] i_stage_pause_ack,
  input  logic [TO_WIDTH-1:0]  i_timeout,
  output logic [NO_STAGES-1:0] o_err_stage,
  input  logic                 i_err_clr,
  output logic                 o_busy,
  output logic [IDX_WIDTH-1:0] o_stage_idx,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_PAUSING, S_PAUSED, S_RESUMING} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NO_STAGES - 1);

  state_t                 r_state, w_state_nxt;
  logic [IDX_WIDTH-1:0]   r_idx, w_idx_nxt;
  logic [TO_WIDTH-1:0]    r_cnt, w_cnt_nxt;
  logic [NO_STAGES-1:0]   r_req, w_req_nxt;
  logic [NO_STAGES-1:0]   r_err, w_err_nxt;
  logic                   r_ack, w_ack_nxt;

  logic w_req_cur, w_ack_cur, w_en_cur, w_to_hit, w_last, w_first;
  logic w_step_pause, w_step_resume;
  logic [TO_WIDTH-1:0] w_cnt_inc;

  assign w_req_cur = r_req[r_idx];
  assign w_ack_cur = i_stage_pause_ack[r_idx];
  assign w_en_cur  = i_stage_en[r_idx];
  assign w_to_hit  = (i_timeout != '0) && (r_cnt == i_timeout - TO_WIDTH'(1));
  assign w_last    = (r_idx == LAST);
  assign w_first   = (r_idx == '0);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + TO_WIDTH'(1);

  // A stage is finished once skipped, or once its request is up and it acked or timed out.
  assign w_step_pause  = (r_state == S_PAUSING) && i_pause_req &&
                         (!w_en_cur || (w_req_cur && (w_ack_cur || w_to_hit)));
  assign w_step_resume = (r_state == S_RESUMING) && !w_req_cur &&
                         (!w_en_cur || !w_ack_cur || w_to_hit);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_req   <= '0;
      r_err   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_err   <= w_err_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (i_pause_req) begin
          w_state_nxt = S_PAUSING;
          w_idx_nxt   = '0;
        end
      end
      S_PAUSING: begin
        if (!i_pause_req) begin
          w_state_nxt = S_RESUMING;
        end else if (w_step_pause) begin
          if (w_last) w_state_nxt = S_PAUSED;
          else        w_idx_nxt   = r_idx + IDX_WIDTH'(1);
        end
      end
      S_PAUSED: begin
        if (!i_pause_req) begin
          w_state_nxt = S_RESUMING;
          w_idx_nxt   = LAST;
        end
      end
      S_RESUMING: begin
        if (w_step_resume) begin
          if (w_first) w_state_nxt = S_IDLE;
          else         w_idx_nxt   = r_idx - IDX_WIDTH'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_req_nxt = r_req;
    w_ack_nxt = r_ack;
    w_cnt_nxt = r_cnt;
    w_err_nxt = i_err_clr ? '0 : r_err;
    case (r_state)
      S_PAUSING: begin
        if (!i_pause_req) begin
          w_cnt_nxt = '0;
        end else if (w_en_cur && !w_req_cur) begin
          w_req_nxt[r_idx] = 1'b1;
          w_cnt_nxt        = '0;
        end else if (w_step_pause) begin
          w_cnt_nxt = '0;
          if (w_en_cur && !w_ack_cur) w_err_nxt[r_idx] = 1'b1;
          if (w_last)                 w_ack_nxt        = 1'b1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_PAUSED: begin
        if (!i_pause_req) w_cnt_nxt = '0;
      end
      S_RESUMING: begin
        if (w_req_cur) begin
          w_req_nxt[r_idx] = 1'b0;
          w_cnt_nxt        = '0;
        end else if (w_step_resume) begin
          w_cnt_nxt = '0;
          if (w_en_cur && w_ack_cur) w_err_nxt[r_idx] = 1'b1;
          if (w_first)               w_ack_nxt        = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  assign o_pause_ack       = r_ack;
  assign o_stage_pause_req = r_req;
  assign o_err_stage       = r_err;
  assign o_busy            = (r_state == S_PAUSING) || (r_state == S_RESUMING);
  assign o_stage_idx       = r_idx;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_adam_pause_seq.sv
// Directed bench for adam_pause_seq with three stages: ordering, skip mask, timeouts,
// abort, reset while paused and pause re-request during resume.
module tb_adam_pause_seq;

  logic       clk;
  logic       rst_n;
  logic       pause_req;
  logic       pause_ack;
  logic [2:0] stage_en;
  logic [2:0] stage_req;
  logic [2:0] stage_ack;
  logic [2:0] loop_mask;
  logic [7:0] timeout;
  logic [2:0] err_stage;
  logic       err_clr;
  logic       busy;
  logic [1:0] stage_idx;
  logic [1:0] dbg_state;

  logic [15:0] exp_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic        seen_req1;

  // Children acknowledge by echoing their request unless masked off.
  assign stage_ack = stage_req & loop_mask;

  adam_pause_seq #(.NO_STAGES(3), .TO_WIDTH(8)) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_pause_req       (pause_req),
    .o_pause_ack       (pause_ack),
    .i_stage_en        (stage_en),
    .o_stage_pause_req (stage_req),
    .i_stage_pause_ack (stage_ack),
    .i_timeout         (timeout),
    .o_err_stage       (err_stage),
    .i_err_clr         (err_clr),
    .o_busy            (busy),
    .o_stage_idx       (stage_idx),
    .o_dbg_state       (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic a, input logic b, input logic [2:0] r,
                                     input logic [2:0] e, input logic [1:0] i);
    return {6'b0, a, b, r, e, i};
  endfunction

  function automatic logic [15:0] snap();
    return {6'b0, pause_ack, busy, stage_req, err_stage, stage_idx};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] exp;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_now(input string tag, input logic [15:0] exp);
    exp_q.push_back(exp);
    check(tag, snap());
  endtask

  task automatic expect_next(input string tag, input logic [15:0] exp);
    exp_q.push_back(exp);
    tick();
    check(tag, snap());
  endtask

  // Counts edges until pause_ack toggles, bounded at 100.
  task automatic wait_ack(input string tag, input int exp_lat);
    logic start;
    int   n;
    start = pause_ack;
    n     = 0;
    exp_q.push_back(16'(exp_lat));
    for (int k = 0; k < 100; k++) begin
      tick();
      n++;
      if (stage_req[1]) seen_req1 = 1'b1;
      if (pause_ack !== start) break;
    end
    check(tag, 16'(n));
  endtask

  initial begin
    rst_n = 1'b0; pause_req = 1'b0; stage_en = 3'b111; timeout = 8'd0;
    err_clr = 1'b0; loop_mask = 3'b111; seen_req1 = 1'b0;
    tick(); tick();
    expect_now("reset", mk(0, 0, 3'b000, 3'b000, 2'd0));
    rst_n = 1'b1;

    // Full loopback pause and resume, edge by edge
    pause_req = 1'b1;
    expect_next("p_e1", mk(0, 1, 3'b000, 3'b000, 2'd0));
    expect_next("p_e2", mk(0, 1, 3'b001, 3'b000, 2'd0));
    expect_next("p_e3", mk(0, 1, 3'b001, 3'b000, 2'd1));
    expect_next("p_e4", mk(0, 1, 3'b011, 3'b000, 2'd1));
    expect_next("p_e5", mk(0, 1, 3'b011, 3'b000, 2'd2));
    expect_next("p_e6", mk(0, 1, 3'b111, 3'b000, 2'd2));
    expect_next("p_e7", mk(1, 0, 3'b111, 3'b000, 2'd2));
    pause_req = 1'b0;
    expect_next("r_e1", mk(1, 1, 3'b111, 3'b000, 2'd2));
    expect_next("r_e2", mk(1, 1, 3'b011, 3'b000, 2'd2));
    expect_next("r_e3", mk(1, 1, 3'b011, 3'b000, 2'd1));
    expect_next("r_e4", mk(1, 1, 3'b001, 3'b000, 2'd1));
    expect_next("r_e5", mk(1, 1, 3'b001, 3'b000, 2'd0));
    expect_next("r_e6", mk(1, 1, 3'b000, 3'b000, 2'd0));
    expect_next("r_e7", mk(0, 0, 3'b000, 3'b000, 2'd0));

    // Stage 1 disabled: one edge saved each way, request never raised
    stage_en = 3'b101; seen_req1 = 1'b0;
    pause_req = 1'b1;
    wait_ack("skip_pause_lat", 6);
    pause_req = 1'b0;
    wait_ack("skip_resume_lat", 6);
    exp_q.push_back(16'd0);
    check("skip_req1_seen", 16'(seen_req1));
    stage_en = 3'b111;

    // Stage 1 never acks, timeout of 8 cycles
    timeout = 8'd8; loop_mask = 3'b101;
    pause_req = 1'b1;
    tick(); tick(); tick();
    expect_next("to_req_set", mk(0, 1, 3'b011, 3'b000, 2'd1));
    repeat (7) tick();
    expect_now("to_wait7", mk(0, 1, 3'b011, 3'b000, 2'd1));
    expect_next("to_hit", mk(0, 1, 3'b011, 3'b010, 2'd2));
    wait_ack("to_pause_tail", 2);
    expect_now("to_paused", mk(1, 0, 3'b111, 3'b010, 2'd2));
    pause_req = 1'b0;
    wait_ack("to_resume_lat", 7);
    expect_now("to_idle", mk(0, 0, 3'b000, 3'b010, 2'd0));
    err_clr = 1'b1;
    expect_next("err_clr", mk(0, 0, 3'b000, 3'b000, 2'd0));
    err_clr = 1'b0;

    // Abort while stage 1 waits for its ack
    timeout = 8'd0;
    pause_req = 1'b1;
    repeat (4) tick();
    expect_next("ab_e5", mk(0, 1, 3'b011, 3'b000, 2'd1));
    pause_req = 1'b0;
    expect_next("ab_e6", mk(0, 1, 3'b011, 3'b000, 2'd1));
    expect_next("ab_e7", mk(0, 1, 3'b001, 3'b000, 2'd1));
    expect_next("ab_e8", mk(0, 1, 3'b001, 3'b000, 2'd0));
    expect_next("ab_e9", mk(0, 1, 3'b000, 3'b000, 2'd0));
    expect_next("ab_e10", mk(0, 0, 3'b000, 3'b000, 2'd0));

    // Timeout coinciding with err_clr keeps the bit, then reset while paused
    timeout = 8'd8;
    pause_req = 1'b1;
    repeat (11) tick();
    err_clr = 1'b1;
    expect_next("clr_vs_to", mk(0, 1, 3'b011, 3'b010, 2'd2));
    err_clr = 1'b0;
    wait_ack("clr_pause_tail", 2);
    expect_now("rst_pre", mk(1, 0, 3'b111, 3'b010, 2'd2));
    rst_n = 1'b0; pause_req = 1'b0;
    expect_next("rst_paused", mk(0, 0, 3'b000, 3'b000, 2'd0));
    rst_n = 1'b1;

    // Pause re-requested mid-resume waits until IDLE
    timeout = 8'd0; loop_mask = 3'b111;
    pause_req = 1'b1;
    wait_ack("re_pause_lat", 7);
    pause_req = 1'b0;
    tick(); tick();
    pause_req = 1'b1;
    expect_next("re_r3", mk(1, 1, 3'b011, 3'b000, 2'd1));
    expect_next("re_r4", mk(1, 1, 3'b001, 3'b000, 2'd1));
    expect_next("re_r5", mk(1, 1, 3'b001, 3'b000, 2'd0));
    expect_next("re_r6", mk(1, 1, 3'b000, 3'b000, 2'd0));
    expect_next("re_r7", mk(0, 0, 3'b000, 3'b000, 2'd0));
    expect_next("re_r8", mk(0, 1, 3'b000, 3'b000, 2'd0));
    expect_next("re_r9", mk(0, 1, 3'b001, 3'b000, 2'd0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
